// File: rtl/mips_vn_memory_pkg.sv
// Shared memory-space constants and MMIO register encoding for the
// von Neumann MIPS memory responder, its core and benches.
package mips_vn_memory_pkg;

  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
  localparam logic [31:0] MEM_ERR_WORD = 32'hDEAD_BEEF;

  // Register select is the word offset inside the MMIO window (byte offset >> 2)
  typedef enum logic [1:0] {
    REG_LEDS    = 2'd0,  // +0x0
    REG_COUNT   = 2'd1,  // +0x4
    REG_COMPARE = 2'd2,  // +0x8
    REG_STATUS  = 2'd3   // +0xC
  } mmio_reg_e;

endpackage

// File: rtl/mips_vn_memory_vn_sync_ram.sv
// Single-port word RAM with synchronous, read-before-write output and a
// clock enable that freezes both the array and the read register.
module vn_sync_ram
  import mips_vn_memory_pkg::*;
#(
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned N         = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic                     i_clk,
  input  logic                     i_ena,
  input  logic                     i_we,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [N-1:0]             i_wdata,
  output logic [N-1:0]             o_rdata
);

  logic [N-1:0] r_mem [WORDS];
  logic [N-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_ena) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_vn_memory.sv
// Unified instruction/data memory for the multicycle MIPS core: RAM, MMIO
// bank (LEDs, cycle timer with compare, status) and error sink.
module mips_vn_memory
  import mips_vn_memory_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned RAM_WORDS = 1024,
  parameter string       INIT_FILE = "",
  parameter int unsigned LED_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N-1:0]     mem_addr,
  input  logic [N-1:0]     mem_wr_data,
  input  logic             mem_wr_ena,
  output logic [N-1:0]     mem_rd_data,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq,
  output logic             bus_error
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic             w_aligned;
  logic             w_is_ram;
  logic             w_is_mmio;
  logic             w_is_err;
  logic             w_wr;
  logic             w_ram_we;
  logic             w_mmio_we;
  mmio_reg_e        w_reg;
  logic [N-1:0]     w_count_nxt;
  logic             w_match;
  logic             w_status_clr;
  logic [N-1:0]     w_mmio_rdata;
  logic [N-1:0]     w_ram_q;

  logic [LED_W-1:0] r_leds;
  logic [N-1:0]     r_count;
  logic [N-1:0]     r_compare;
  logic             r_status;
  logic             r_bus_error;
  logic [N-1:0]     r_mmio_rd;
  logic             r_rd_from_ram;

  // Address decode; anything not an aligned RAM or MMIO word is an error
  always_comb begin
    w_aligned = (mem_addr[1:0] == 2'b00);
    w_is_ram  = w_aligned && (mem_addr[N-1:AW+2] == '0);
    w_is_mmio = w_aligned && (mem_addr[N-1:4] == MMIO_BASE[N-1:4]);
    w_is_err  = !(w_is_ram || w_is_mmio);
    w_reg     = mmio_reg_e'(mem_addr[3:2]);
  end

  // Reset suppresses every write, including the RAM one
  assign w_wr      = ena && mem_wr_ena && !rst;
  assign w_ram_we  = w_wr && w_is_ram;
  assign w_mmio_we = w_wr && w_is_mmio;

  // Timer: a COUNT write overrides the increment; match tests the new value
  always_comb begin
    w_count_nxt  = r_count + N'(1);
    if (w_mmio_we && (w_reg == REG_COUNT)) w_count_nxt = mem_wr_data;
    w_match      = (w_count_nxt == r_compare);
    w_status_clr = w_mmio_we && (w_reg == REG_STATUS) && mem_wr_data[0];
  end

  // MMIO read mux samples register values from before this edge
  always_comb begin
    w_mmio_rdata = '0;
    case (w_reg)
      REG_LEDS:    w_mmio_rdata = N'(r_leds);
      REG_COUNT:   w_mmio_rdata = r_count;
      REG_COMPARE: w_mmio_rdata = r_compare;
      REG_STATUS:  w_mmio_rdata = N'(r_status);
      default:     w_mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds        <= '0;
      r_count       <= '0;
      r_compare     <= '1;
      r_status      <= 1'b0;
      r_bus_error   <= 1'b0;
      r_mmio_rd     <= '0;
      r_rd_from_ram <= 1'b0;
    end else if (ena) begin
      r_count <= w_count_nxt;
      if (w_match)           r_status <= 1'b1;
      else if (w_status_clr) r_status <= 1'b0;
      if (w_mmio_we && (w_reg == REG_LEDS))    r_leds    <= mem_wr_data[LED_W-1:0];
      if (w_mmio_we && (w_reg == REG_COMPARE)) r_compare <= mem_wr_data;
      if (w_is_err) r_bus_error <= 1'b1;
      r_rd_from_ram <= w_is_ram;
      r_mmio_rd     <= w_is_err ? N'(MEM_ERR_WORD) : w_mmio_rdata;
    end
  end

  vn_sync_ram #(
    .WORDS     (RAM_WORDS),
    .N         (N),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (clk),
    .i_ena   (ena),
    .i_we    (w_ram_we),
    .i_addr  (mem_addr[AW+1:2]),
    .i_wdata (mem_wr_data),
    .o_rdata (w_ram_q)
  );

  // Both sources are registered on the same edge; pick the one that was addressed
  assign mem_rd_data = r_rd_from_ram ? w_ram_q : r_mmio_rd;
  assign leds        = r_leds;
  assign timer_irq   = r_status;
  assign bus_error   = r_bus_error;

endmodule

// File: tb/tb_mips_vn_memory.sv
// Scoreboard bench for mips_vn_memory: directed scenarios then random
// accesses, checked against a behavioural memory-map model.
module tb_mips_vn_memory;

  localparam int unsigned RAM_WORDS = 1024;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic        timer_irq;
  logic        bus_error;

  mips_vn_memory #(
    .N         (32),
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE (""),
    .LED_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .leds        (leds),
    .timer_irq   (timer_irq),
    .bus_error   (bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] rd;
    bit          rd_known;
    logic [7:0]  leds;
    bit          irq;
    bit          berr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_rd;
  bit          m_known;
  logic [7:0]  m_leds;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  bit          m_status;
  bit          m_berr;

  task automatic model_step(input bit r, input bit e, input logic [31:0] a,
                            input bit w, input logic [31:0] d);
    bit          aligned, is_ram, is_mmio;
    logic [31:0] off, nc;
    if (r) begin
      m_rd = 0; m_known = 1; m_leds = 0; m_count = 0;
      m_compare = 32'hFFFF_FFFF; m_status = 0; m_berr = 0;
      return;
    end
    if (!e) return;
    aligned = (a % 4) == 0;
    is_ram  = aligned && (a < RAM_WORDS * 4);
    is_mmio = aligned && (a >= 32'h8000_0000) && (a <= 32'h8000_000C);
    off     = a - 32'h8000_0000;
    if (is_ram) begin
      m_known = m_ram.exists(int'(a / 4));
      m_rd    = m_known ? m_ram[int'(a / 4)] : 32'h0;
    end else if (is_mmio) begin
      m_known = 1;
      case (off)
        32'h0:   m_rd = {24'h0, m_leds};
        32'h4:   m_rd = m_count;
        32'h8:   m_rd = m_compare;
        default: m_rd = {31'h0, m_status};
      endcase
    end else begin
      m_known = 1;
      m_rd    = 32'hDEAD_BEEF;
      m_berr  = 1;
    end
    nc = m_count + 1;
    if (w && is_mmio && off == 32'h4) nc = d;
    if (w && is_ram) m_ram[int'(a / 4)] = d;
    if (w && is_mmio && off == 32'h0) m_leds = d[7:0];
    if (nc == m_compare) m_status = 1;
    else if (w && is_mmio && off == 32'hC && d[0]) m_status = 0;
    if (w && is_mmio && off == 32'h8) m_compare = d;
    m_count = nc;
  endtask

  task automatic cyc(input bit r, input bit e, input logic [31:0] a,
                     input bit w, input logic [31:0] d);
    exp_t x;
    @(negedge clk);
    rst = r; ena = e; mem_addr = a; mem_wr_ena = w; mem_wr_data = d;
    model_step(r, e, a, w, d);
    x.id = step_id; x.rd = m_rd; x.rd_known = m_known;
    x.leds = m_leds; x.irq = m_status; x.berr = m_berr;
    exp_q.push_back(x);
    step_id++;
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(0, 1, a, 0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, a, 1, d);
  endtask

  function automatic void chk(string nm, int id, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, got, want);
    end
  endfunction

  // Monitor: every edge after stimulus starts yields one response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rd_known) chk("mem_rd_data", e.id, mem_rd_data, e.rd);
        chk("leds", e.id, {24'h0, leds}, {24'h0, e.leds});
        chk("timer_irq", e.id, {31'h0, timer_irq}, {31'h0, e.irq});
        chk("bus_error", e.id, {31'h0, bus_error}, {31'h0, e.berr});
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    rst = 1; ena = 0; mem_addr = 0; mem_wr_ena = 0; mem_wr_data = 0;
    m_known = 0; m_rd = 0; m_leds = 0; m_count = 0;
    m_compare = 32'hFFFF_FFFF; m_status = 0; m_berr = 0;

    // Reset and COMPARE reset value
    cyc(1, 1, 32'h0, 0, 32'h0);
    cyc(1, 1, 32'h0, 0, 32'h0);
    rd(32'h8000_0008);
    rd(32'h8000_000C);

    // RAM round trip and read-before-write
    wr(32'h10, 32'h1234_5678);
    rd(32'h10);
    wr(32'h10, 32'hAAAA_AAAA);
    rd(32'h10);
    wr(32'hFFC, 32'h0BAD_F00D);
    rd(32'hFFC);

    // Timer wrap and match
    wr(32'h8000_0004, 32'hFFFF_FFFE);
    wr(32'h8000_0008, 32'h0000_0001);
    rd(32'h8000_0004);
    rd(32'h8000_0004);
    rd(32'h8000_0004);
    rd(32'h8000_000C);

    // Status clear, then W1C colliding with a match edge
    wr(32'h8000_000C, 32'h1);
    rd(32'h8000_000C);
    wr(32'h8000_0004, 32'h0);
    wr(32'h8000_000C, 32'h1);
    rd(32'h8000_000C);

    // Error sink: misaligned read, unmapped write, edges of the map
    rd(32'h0000_0002);
    wr(32'h4000_0000, 32'h5555_5555);
    rd(32'h10);
    rd(32'h0000_1000);
    rd(32'h8000_0010);
    cyc(1, 1, 32'h10, 1, 32'h7777_7777);
    rd(32'h10);

    // Enable hold
    wr(32'h8000_0000, 32'h0000_005A);
    rd(32'h8000_0004);
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h8000_0000, 1, 32'hFF);
    cyc(0, 0, 32'h10, 1, 32'h0);
    rd(32'h8000_0004);
    rd(32'h10);
    rd(32'h8000_0000);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15)) << 2;
        5, 6:          a = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 2);
        7:             a = ($urandom_range(0, 1) != 0) ? 32'h0000_0FFC : 32'h0000_1000;
        8:             a = 32'h8000_0000 + 32'($urandom_range(1, 3));
        default:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_0010 : 32'h4000_0000;
      endcase
      d = ($urandom_range(0, 3) == 0) ? m_compare - 32'($urandom_range(0, 3)) : $urandom;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), a,
          ($urandom_range(0, 1) != 0), d);
    end

    @(negedge clk);
    rst = 0; ena = 0; mem_wr_ena = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
